// File: rtl/array_26_ctrl_pkg.sv
// rtl/array_26_ctrl_pkg.sv - shared widths, state encoding and request record for array_26_ctrl
package array_26_ctrl_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 42;
    localparam int MASK_W = 6;
    localparam int DEPTH  = 8192;
    localparam int LANE_W = DATA_W / MASK_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/array_26_ctrl_rr_arb2.sv
// rtl/array_26_ctrl_rr_arb2.sv - two-way round-robin arbiter; pointer moves only on contended grants
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    always_comb begin
        grant    = valid;
        rr_ptr_d = rr_ptr_q;
        if (valid == 2'b11) begin
            grant = rr_ptr_q ? 2'b10 : 2'b01;
        end
        if (advance) begin
            rr_ptr_d = ~rr_ptr_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/array_26_ctrl.sv
// rtl/array_26_ctrl.sv - init sweep plus two-port round-robin front end for the 8192x42 RW macro
module array_26_ctrl
    import array_26_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              init_done,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic              req_write_0,
    input  logic              req_write_1,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [MASK_W-1:0] req_wmask_0,
    input  logic [MASK_W-1:0] req_wmask_1,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;

    logic       run;
    logic [1:0] valid;
    logic [1:0] grant;
    logic       advance;
    req_t       req_0, req_1, req_sel;
    logic       mem_en_c;

    assign run     = (state_q == ST_RUN);
    assign valid   = {req_valid_1, req_valid_0};
    assign advance = run & valid[0] & valid[1];

    assign req_0 = '{write: req_write_0, addr: req_addr_0, wmask: req_wmask_0, wdata: req_wdata_0};
    assign req_1 = '{write: req_write_1, addr: req_addr_1, wmask: req_wmask_1, wdata: req_wdata_1};
    assign req_sel = grant[1] ? req_1 : req_0;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .valid   (valid),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + ADDR_W'(1);
                if (init_ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d    = ST_INIT;
                    init_ptr_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_ptr_d = '0;
            end
        endcase
    end

    // A read granted in the clear cycle still completes; only reads produce a response.
    always_comb begin
        rsp_valid_d[0] = run & grant[0] & ~req_write_0;
        rsp_valid_d[1] = run & grant[1] & ~req_write_1;
    end

    always_comb begin
        mem_en_c  = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (state_q == ST_INIT) begin
            mem_en_c  = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = init_ptr_q;
            mem_wmask = '1;
            mem_wdata = INIT_VALUE;
        end else if (|grant) begin
            mem_en_c  = 1'b1;
            mem_wmode = req_sel.write;
            mem_addr  = req_sel.addr;
            mem_wmask = req_sel.wmask;
            mem_wdata = req_sel.wdata;
        end
    end

    // Reset forces INIT, which would otherwise enable the macro while reset is held.
    assign mem_en = reset_n & mem_en_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign init_done   = run;
    assign req_ready_0 = run & grant[0];
    assign req_ready_1 = run & grant[1];
    assign rsp_valid_0 = rsp_valid_q[0];
    assign rsp_valid_1 = rsp_valid_q[1];
    assign rsp_rdata   = mem_rdata;

endmodule

// File: tb/tb_array_26_ctrl.sv
// tb/tb_array_26_ctrl.sv - directed self-checking bench for array_26_ctrl with a behavioural macro
module tb_array_26_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        init_done;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic        req_ready_0, req_ready_1;
    logic        req_write_0 = 1'b0, req_write_1 = 1'b0;
    logic [12:0] req_addr_0 = '0, req_addr_1 = '0;
    logic [5:0]  req_wmask_0 = '0, req_wmask_1 = '0;
    logic [41:0] req_wdata_0 = '0, req_wdata_1 = '0;
    logic        rsp_valid_0, rsp_valid_1;
    logic [41:0] rsp_rdata;
    logic [12:0] mem_addr;
    logic        mem_en, mem_wmode;
    logic [5:0]  mem_wmask;
    logic [41:0] mem_wdata;
    logic [41:0] mem_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    array_26_ctrl dut (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .init_done(init_done),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_write_0(req_write_0), .req_write_1(req_write_1),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
        .req_wmask_0(req_wmask_0), .req_wmask_1(req_wmask_1),
        .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural single-port macro, 7-bit write lanes, 1-cycle read latency.
    logic [41:0] mem [0:8191];
    logic [41:0] rdata_q = '0;
    assign mem_rdata = rdata_q;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) begin
                for (int l = 0; l < 6; l++) begin
                    if (mem_wmask[l]) mem[mem_addr][l*7 +: 7] <= mem_wdata[l*7 +: 7];
                end
            end else begin
                rdata_q <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge right after the sweep starts at address 0.
    task automatic check_sweep(input string tag);
        int bad = 0;
        for (int k = 0; k < 8192; k++) begin
            #1;
            if (mem_addr !== 13'(k) || mem_en !== 1'b1 || mem_wmode !== 1'b1 ||
                mem_wmask !== 6'h3F || mem_wdata !== 42'h0 || init_done !== 1'b0 ||
                req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) bad++;
            @(posedge clock);
            @(negedge clock);
        end
        chk({tag, "_sweep_bad_cycles"}, 64'(bad), 64'd0);
        #1;
        chk({tag, "_init_done"}, 64'(init_done), 64'd1);
    endtask

    // Single-port transaction; returns at the negedge after acceptance with inputs idle.
    task automatic single_op(input int p, input logic wr, input logic [12:0] a,
                             input logic [5:0] m, input logic [41:0] d, input logic [41:0] exp_rd);
        @(negedge clock);
        if (p == 0) begin
            req_valid_0 = 1'b1; req_write_0 = wr; req_addr_0 = a; req_wmask_0 = m; req_wdata_0 = d;
        end else begin
            req_valid_1 = 1'b1; req_write_1 = wr; req_addr_1 = a; req_wmask_1 = m; req_wdata_1 = d;
        end
        #1;
        chk($sformatf("ready_p%0d", p), 64'(p == 0 ? req_ready_0 : req_ready_1), 64'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        #1;
        if (!wr) begin
            chk($sformatf("rsp_valid_p%0d", p), 64'(p == 0 ? rsp_valid_0 : rsp_valid_1), 64'd1);
            chk($sformatf("rsp_rdata_p%0d_%0h", p, a), 64'(rsp_rdata), 64'(exp_rd));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 42'h2AA_AAAA_AAAA ^ 42'(i);

        // Reset with both ports requesting.
        req_valid_0 = 1'b1; req_addr_0 = 13'h0001;
        req_valid_1 = 1'b1; req_addr_1 = 13'h0002;
        #2;
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_ready", 64'({req_ready_1, req_ready_0}), 64'd0);
        chk("rst_rsp_valid", 64'({rsp_valid_1, rsp_valid_0}), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check_sweep("boot");
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        single_op(0, 1'b0, 13'h1FFF, 6'h0, 42'h0, 42'h0);

        // Masked write covering lanes 0 and 1, then read back with exact latency.
        single_op(0, 1'b1, 13'h0123, 6'b000011, 42'h3_FFFF_FFFF_FF, 42'h0);
        single_op(0, 1'b0, 13'h0123, 6'h0, 42'h0, 42'h0000_0003FFF);
        @(negedge clock);
        #1;
        chk("rsp_valid_0_one_cycle", 64'(rsp_valid_0), 64'd0);
        single_op(1, 1'b1, 13'h0123, 6'b000000, 42'h1_2345_6789, 42'h0);
        single_op(1, 1'b0, 13'h0123, 6'h0, 42'h0, 42'h0000_0003FFF);

        // Contended reads alternate starting with port 0.
        single_op(0, 1'b1, 13'h0200, 6'h3F, 42'h111, 42'h0);
        single_op(1, 1'b1, 13'h0300, 6'h3F, 42'h222, 42'h0);
        @(negedge clock);
        req_valid_0 = 1'b1; req_write_0 = 1'b0; req_addr_0 = 13'h0200;
        req_valid_1 = 1'b1; req_write_1 = 1'b0; req_addr_1 = 13'h0300;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                req_valid_0 = 1'b0;
                req_valid_1 = 1'b0;
            end
            #1;
            if (i < 4) begin
                chk($sformatf("alt_ready0_%0d", i), 64'(req_ready_0), 64'(i % 2 == 0));
                chk($sformatf("alt_ready1_%0d", i), 64'(req_ready_1), 64'(i % 2 == 1));
            end
            if (i > 0) begin
                chk($sformatf("alt_rsp0_%0d", i), 64'(rsp_valid_0), 64'((i - 1) % 2 == 0));
                chk($sformatf("alt_rsp1_%0d", i), 64'(rsp_valid_1), 64'((i - 1) % 2 == 1));
                chk($sformatf("alt_data_%0d", i), 64'(rsp_rdata),
                    ((i - 1) % 2 == 0) ? 64'h111 : 64'h222);
            end
            @(posedge clock);
            @(negedge clock);
        end

        // Port 1 alone with rr_ptr at 0: always granted, pointer left alone.
        req_valid_1 = 1'b1; req_write_1 = 1'b0; req_addr_1 = 13'h0300;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("solo1_ready_%0d", i), 64'({req_ready_1, req_ready_0}), 64'b10);
            @(posedge clock);
            @(negedge clock);
        end
        req_valid_0 = 1'b1; req_write_0 = 1'b0; req_addr_0 = 13'h0200;
        #1;
        chk("solo1_rr_unchanged", 64'({req_ready_1, req_ready_0}), 64'b01);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;

        // Read accepted in the clear cycle returns pre-clear data, then a full sweep.
        single_op(1, 1'b1, 13'h0010, 6'h3F, 42'h155, 42'h0);
        @(negedge clock);
        req_valid_1 = 1'b1; req_write_1 = 1'b0; req_addr_1 = 13'h0010;
        clear_req = 1'b1;
        #1;
        chk("clear_ready1", 64'(req_ready_1), 64'd1);
        @(posedge clock);
        @(negedge clock);
        clear_req = 1'b0;
        req_valid_1 = 1'b0;
        #1;
        chk("clear_rsp_valid1", 64'(rsp_valid_1), 64'd1);
        chk("clear_rsp_data", 64'(rsp_rdata), 64'h155);
        #1;
        check_sweep("clear");
        single_op(1, 1'b0, 13'h0010, 6'h0, 42'h0, 42'h0);
        single_op(0, 1'b0, 13'h0123, 6'h0, 42'h0, 42'h0);

        // Reset in the middle of a sweep restarts it from address 0.
        @(negedge clock);
        clear_req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear_req = 1'b0;
        for (int i = 0; i < 13'h0800; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        #1;
        chk("mid_sweep_addr", 64'(mem_addr), 64'h800);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check_sweep("restart");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/array_26_ctrl.md
Name: array_26_ctrl

Overview:
- Controller for the 8192x42 single-port array macro: 13-bit address, 6 write-mask lanes of 7 bits each, 1-cycle read latency, no simultaneous read and write.
- After reset, or on a clear request, sweeps the whole array to INIT_VALUE.
- In normal operation, shares the single RW port between two requesters using round-robin arbitration and returns read data with a per-port valid.
- Sits between the requesting pipelines and the macro; it is the only driver of the macro's RW port.

Parameters:
- ADDR_W, 13, address width
- DATA_W, 42, data width
- MASK_W, 6, mask lanes; lane width = DATA_W/MASK_W = 7
- DEPTH, 8192, number of entries; must equal 2**ADDR_W
- INIT_VALUE, 42'h0, value written during the init sweep

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- clear_req  in  1  pulse; request a re-initialisation sweep
- init_done  out  1  high when the array is initialised and requests are served
- req_valid_0 / req_valid_1  in  1  request valid, per port
- req_ready_0 / req_ready_1  out  1  request accepted this cycle, per port
- req_write_0 / req_write_1  in  1  1 = write, 0 = read
- req_addr_0 / req_addr_1  in  ADDR_W  address
- req_wmask_0 / req_wmask_1  in  MASK_W  per-lane write enable
- req_wdata_0 / req_wdata_1  in  DATA_W  write data
- rsp_valid_0 / rsp_valid_1  out  1  read data valid on rsp_rdata
- rsp_rdata  out  DATA_W  shared read data, qualified by rsp_valid_x
- mem_addr  out  ADDR_W  to macro RW0_addr
- mem_en  out  1  to RW0_en
- mem_wmode  out  1  to RW0_wmode
- mem_wmask  out  MASK_W  to RW0_wmask
- mem_wdata  out  DATA_W  to RW0_wdata
- mem_rdata  in  DATA_W  from RW0_rdata

Behaviour:
- Reset (async assert, sync release):
  - state = INIT, init_ptr = 0, rr_ptr = 0.
  - init_done = 0, rsp_valid_0/1 = 0, req_ready_0/1 = 0.
  - mem_en = 0 while reset_n is low.
- State INIT:
  - Every cycle: mem_en = 1, mem_wmode = 1, mem_wmask = all ones, mem_wdata = INIT_VALUE, mem_addr = init_ptr; init_ptr increments.
  - The sweep takes exactly DEPTH cycles.
  - The cycle that writes address DEPTH-1 transitions to RUN; init_ptr wraps to 0.
  - init_done rises the cycle after that last write.
  - req_ready_0/1 = 0 throughout; clear_req is ignored.
- State RUN, arbitration:
  - init_done = 1.
  - Exactly one valid port: that port is granted.
  - Both ports valid: the port selected by rr_ptr is granted, and rr_ptr then points to the other port.
  - rr_ptr updates only on a contended grant.
  - Worst-case wait for a valid request is 1 cycle.
  - req_ready_x = RUN & grant_x. It depends combinationally on both req_valid signals, so requesters must not make req_valid wait on req_ready.
- State RUN, memory drive:
  - mem_* are driven combinationally from the granted port: mem_en = 1, mem_wmode = req_write, plus addr, wmask, wdata.
  - No grant: mem_en = 0.
- Reads:
  - rsp_valid_x is registered and high exactly 1 cycle after a read accept on port x.
  - rsp_rdata = mem_rdata, passed through combinationally.
  - There is no response backpressure; requesters must sink responses.
  - A masked write with wmask = 0 is a legal no-op and still consumes the slot.
- clear_req in RUN:
  - Any request presented in the same cycle is still arbitrated and accepted.
  - Next state is INIT with init_ptr = 0; init_done drops the next cycle.
  - A read accepted in the clear cycle still returns rsp_valid on the following cycle, with pre-clear data.
- Reset mid-sweep restarts the sweep at address 0.
- mem_rdata outside a valid response window is don't-care; rsp_valid_0/1 must never be high in such a cycle.

Decomposition:
- Package array_26_ctrl_pkg:
  - ADDR_W, DATA_W, MASK_W, DEPTH, LANE_W constants.
  - State enum {INIT, RUN}, 1 bit.
  - Request struct {write, addr, wmask, wdata}.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: valid[1:0], advance.
  - Outputs: grant[1:0], holding rr_ptr.
  - Reset: rr_ptr = 0.

Test Plan:
- Release reset with both ports valid -> req_ready stays 0 for 8192 cycles; init_done rises in cycle 8193; a read of 0x1FFF returns 42'h0.
- Port 0 writes addr 0x0123, data 42'h3_FFFF_FFFF_FF, mask 6'b000011; then port 0 reads 0x0123 -> rsp_valid_0 exactly 1 cycle after accept; rsp_rdata = 42'h0000_0003FFF.
- Both ports hold continuous reads to different addresses -> grants alternate 0,1,0,1 starting with port 0; each response goes to the correct rsp_valid_x with the correct data.
- Port 1 read accepted in the same cycle as clear_req, with addr 0x0010 previously written to 42'h155 -> rsp_valid_1 next cycle with 42'h155; init_done low for 8192 cycles; a re-read then returns 0.
- Assert reset_n low at init_ptr = 0x0800, then release -> mem_en deasserts immediately; the sweep restarts at mem_addr 0 and still takes the full 8192 cycles.
- Only port 1 valid for 5 cycles while rr_ptr = 0 -> port 1 granted every cycle; rr_ptr unchanged.
